// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
//   Shared types and helpers for the Johnson (twisted-ring) step sequencer.
//   - state_e      : controller FSM states (IDLE / RUN / HOLD)
//   - DIR_FWD/REV  : encoding of the direction input
//   - johnson_next : next Johnson pattern for a given direction and width
// -----------------------------------------------------------------------------
package johnson_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Widest ring the helper below can handle; callers zero-extend into it.
    localparam int JOHNSON_MAX_W = 32;

    // Forward: shift right, inverted LSB enters at the MSB.
    // Reverse: shift left, inverted MSB enters at the LSB.
    // Written with masks rather than variable bit-selects so the same function
    // serves any ring width up to JOHNSON_MAX_W. Bits at or above 'width' come
    // back as zero.
    function automatic logic [JOHNSON_MAX_W-1:0] johnson_next(
        input logic [JOHNSON_MAX_W-1:0] pattern,
        input logic                     dir,
        input int unsigned              width
    );
        logic [JOHNSON_MAX_W-1:0] msb;
        logic [JOHNSON_MAX_W-1:0] valid;
        logic [JOHNSON_MAX_W-1:0] result;
        msb   = JOHNSON_MAX_W'(1) << (width - 1);
        valid = (msb << 1) - JOHNSON_MAX_W'(1);
        if (dir == DIR_FWD) begin
            result = (pattern & valid) >> 1;
            if (!pattern[0]) begin
                result = result | msb;
            end
        end else begin
            result    = (pattern << 1) & valid;
            result[0] = ~|(pattern & msb);
        end
        return result;
    endfunction

endpackage

// File: rtl/johnson_core.sv
// -----------------------------------------------------------------------------
// johnson_core
//   Johnson counter datapath: holds the ring pattern and its phase index and
//   advances both by one position whenever step_en is high.
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   synchronous, active-low reset (pattern=0, phase=0)
//     step_en  in   advance one position this cycle
//     dir      in   DIR_FWD / DIR_REV
//     pattern  out  WIDTH-bit Johnson value
//     phase    out  index 0..2*WIDTH-1 of pattern in the forward sequence
// -----------------------------------------------------------------------------
module johnson_core
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           step_en,
    input  logic                           dir,
    output logic [WIDTH-1:0]               pattern,
    output logic [$clog2(2*WIDTH)-1:0]     phase
);

    localparam int              PH_W    = $clog2(2*WIDTH);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2*WIDTH - 1);

    logic [WIDTH-1:0]         pattern_q, pattern_d;
    logic [PH_W-1:0]          phase_q, phase_d;
    logic [JOHNSON_MAX_W-1:0] pattern_ext;

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        pattern_d                = pattern_q;
        phase_d                  = phase_q;
        pattern_ext              = '0;
        pattern_ext[WIDTH-1:0]   = pattern_q;
        if (step_en) begin
            pattern_d = WIDTH'(johnson_next(pattern_ext, dir, unsigned'(WIDTH)));
            if (dir == DIR_FWD) begin
                phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            end else begin
                phase_d = (phase_q == '0) ? PH_LAST : phase_q - PH_W'(1);
            end
        end
    end

    // NOTE: reset is synchronous, so only clk is in the sensitivity list; the
    // state update uses non-blocking assignments so every flop samples the
    // pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pattern_q <= '0;
            phase_q   <= '0;
        end else begin
            pattern_q <= pattern_d;
            phase_q   <= phase_d;
        end
    end

    assign pattern = pattern_q;
    assign phase   = phase_q;

endmodule

// File: rtl/johnson_step_ctrl.sv
// -----------------------------------------------------------------------------
// johnson_step_ctrl
//   Step sequencer for a WIDTH-stage Johnson counter. A start command latches
//   direction, step count and rate; the counter then advances one position
//   every div+1 cycles until the count is exhausted (done pulse), stop aborts,
//   or forever when steps=0. pause freezes the rate prescaler.
//   Ports:
//     clk, rst   clock (rising edge), synchronous active-low reset
//     start      command pulse, accepted only while idle
//     dir        0 forward / 1 reverse, sampled with start
//     steps      steps to execute, 0 = continuous
//     div        one step every div+1 cycles, sampled with start
//     pause      level, freezes sequencing while high
//     stop       abort, back to idle without done
//     pattern    Johnson counter value
//     phase      sequence index of pattern
//     busy       command in progress (RUN or HOLD)
//     done       one-cycle pulse when a finite command completes
// -----------------------------------------------------------------------------
module johnson_step_ctrl
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8,
    parameter int DIV_W = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           dir,
    input  logic [CNT_W-1:0]               steps,
    input  logic [DIV_W-1:0]               div,
    input  logic                           pause,
    input  logic                           stop,
    output logic [WIDTH-1:0]               pattern,
    output logic [$clog2(2*WIDTH)-1:0]     phase,
    output logic                           busy,
    output logic                           done
);

    state_e             state_q, state_d;
    logic               dir_q, dir_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   prescaler_q, prescaler_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic               done_q, done_d;
    logic               tick;
    logic               step_en;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        div_d       = div_q;
        prescaler_d = prescaler_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        tick        = 1'b0;
        step_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    dir_d       = dir;
                    div_d       = div;
                    prescaler_d = '0;
                    remaining_d = steps;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_HOLD;
                end else begin
                    tick = 1'b1;
                end
            end
            ST_HOLD: begin
                // Leaving HOLD also counts as a normal run cycle, so each
                // cycle with pause high delays later steps by exactly one.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    state_d = ST_RUN;
                    tick    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tick) begin
            if (prescaler_q == div_q) begin
                step_en     = 1'b1;
                prescaler_d = '0;
                // A finite command never lets remaining reach zero while busy
                // (it ends on the 1 -> 0 step), so zero here means continuous.
                if (remaining_q != '0) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                prescaler_d = prescaler_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_FWD;
            div_q       <= '0;
            prescaler_q <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            div_q       <= div_d;
            prescaler_q <= prescaler_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
        end
    end

    johnson_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .step_en (step_en),
        .dir     (dir_q),
        .pattern (pattern),
        .phase   (phase)
    );

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_johnson_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_johnson_step_ctrl
//   Directed scenarios plus a randomized run, all compared cycle by cycle with
//   a behavioural model that tracks only phase, busy/done and a tick count;
//   the expected pattern is computed arithmetically from the phase.
// -----------------------------------------------------------------------------
module tb_johnson_step_ctrl;

    localparam int WIDTH  = 4;
    localparam int CNT_W  = 8;
    localparam int DIV_W  = 8;
    localparam int PH_W   = 3;
    localparam int PERIOD = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             dir;
    logic [CNT_W-1:0] steps;
    logic [DIV_W-1:0] div;
    logic             pause;
    logic             stop;
    logic [WIDTH-1:0] dut_pattern;
    logic [PH_W-1:0]  dut_phase;
    logic             dut_busy;
    logic             dut_done;

    always #5 clk = ~clk;

    johnson_step_ctrl #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dir     (dir),
        .steps   (steps),
        .div     (div),
        .pause   (pause),
        .stop    (stop),
        .pattern (dut_pattern),
        .phase   (dut_phase),
        .busy    (dut_busy),
        .done    (dut_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_busy  = 1'b0;
    bit m_done  = 1'b0;
    bit m_dir   = 1'b0;
    int m_phase = 0;
    int m_div   = 0;
    int m_steps = 0;
    int m_left  = 0;
    int m_ticks = 0;

    // Position p of the forward sequence: p ones entering from the MSB side
    // for p <= WIDTH, then 2*WIDTH-p ones remaining at the LSB side.
    function automatic logic [WIDTH-1:0] pattern_of(input int p);
        if (p <= WIDTH) return WIDTH'(((1 << p) - 1) << (WIDTH - p));
        return WIDTH'((1 << (2 * WIDTH - p)) - 1);
    endfunction

    // Vector layout: {pattern[3:0], phase[2:0], busy, done}
    function automatic logic [8:0] obs_vec();
        return {dut_pattern, dut_phase, dut_busy, dut_done};
    endfunction

    function automatic logic [8:0] exp_vec();
        return {pattern_of(m_phase), PH_W'(m_phase), m_busy, m_done};
    endfunction

    task automatic model_edge();
        if (!rst) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_phase = 0;
            m_left  = 0;
            m_ticks = 0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (start) begin
                m_busy  = 1'b1;
                m_dir   = dir;
                m_div   = int'(div);
                m_steps = int'(steps);
                m_left  = m_steps;
                m_ticks = 0;
            end
        end else begin
            m_done = 1'b0;
            if (stop) begin
                m_busy = 1'b0;
            end else if (!pause) begin
                m_ticks++;
                if (m_ticks == m_div + 1) begin
                    m_ticks = 0;
                    m_phase = m_dir ? (m_phase + PERIOD - 1) % PERIOD : (m_phase + 1) % PERIOD;
                    if (m_steps != 0) begin
                        m_left--;
                        if (m_left == 0) begin
                            m_busy = 1'b0;
                            m_done = 1'b1;
                        end
                    end
                end
            end
        end
    endtask

    // Advance the model for the coming edge, then let the edge happen and
    // settle; inputs are changed only after this returns.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; dir = 1'b0; steps = '0; div = '0;
        pause = 1'b0; stop = 1'b0;
        tick();
        tick();
        n_checks++;
        if (obs_vec() !== 9'b0) begin
            n_errors++;
            $display("FAIL reset_state: got %b expected %b", obs_vec(), 9'b0);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (obs_vec() !== exp_vec() || dut_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: got %b expected %b", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_forward();
        logic [WIDTH-1:0] fwd_exp [8];
        int               n_done;
        fwd_exp = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        n_done  = 0;
        dir = 1'b0; steps = 8'd8; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (dut_busy !== 1'b1 || dut_pattern !== 4'b0000) begin
            n_errors++;
            $display("FAIL fwd_start: got busy=%b pattern=%b expected busy=1 pattern=0000", dut_busy, dut_pattern);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (dut_done === 1'b1) n_done++;
            n_checks++;
            if (dut_pattern !== fwd_exp[k] || obs_vec() !== exp_vec() || dut_done !== (k == 7)) begin
                n_errors++;
                $display("FAIL fwd_step %0d: got %b expected pattern %b model %b", k, obs_vec(), fwd_exp[k], exp_vec());
            end
        end
        n_checks++;
        if (dut_phase !== 3'd0 || dut_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL fwd_end: got phase=%0d busy=%b expected phase=0 busy=0", dut_phase, dut_busy);
        end
        tick();
        n_checks++;
        if (dut_done !== 1'b0 || n_done != 1) begin
            n_errors++;
            $display("FAIL fwd_done_pulse: got done=%b pulses=%0d expected done=0 pulses=1", dut_done, n_done);
        end
    endtask

    task automatic test_reverse();
        logic [WIDTH-1:0] rev_exp [3];
        logic [PH_W-1:0]  rev_ph  [3];
        rev_exp = '{4'b0001, 4'b0011, 4'b0111};
        rev_ph  = '{3'd7, 3'd6, 3'd5};
        dir = 1'b1; steps = 8'd3; div = 8'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec() || dut_done !== (k == 9)) begin
                n_errors++;
                $display("FAIL rev_cycle %0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
            if (k % 3 == 0) begin
                n_checks++;
                if (dut_pattern !== rev_exp[k/3-1] || dut_phase !== rev_ph[k/3-1]) begin
                    n_errors++;
                    $display("FAIL rev_step %0d: got pattern=%b phase=%0d expected pattern=%b phase=%0d",
                             k, dut_pattern, dut_phase, rev_exp[k/3-1], rev_ph[k/3-1]);
                end
            end
        end
    endtask

    task automatic test_continuous();
        int n_done;
        n_done = 0;
        reset_pulse();
        // stop and pause have no effect while idle
        stop = 1'b1; pause = 1'b1;
        tick();
        stop = 1'b0; pause = 1'b0;
        n_checks++;
        if (obs_vec() !== 9'b0) begin
            n_errors++;
            $display("FAIL idle_ignore: got %b expected %b", obs_vec(), 9'b0);
        end
        dir = 1'b0; steps = 8'd0; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (dut_done === 1'b1) n_done++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL cont_cycle %0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (dut_pattern !== 4'b1111 || dut_phase !== 3'd4 || dut_busy !== 1'b0 || dut_done !== 1'b0) begin
                n_errors++;
                $display("FAIL cont_stop_hold %0d: got %b expected pattern=1111 phase=4 busy=0 done=0", k, obs_vec());
            end
            tick();
        end
        n_checks++;
        if (n_done != 0) begin
            n_errors++;
            $display("FAIL cont_no_done: got %0d pulses expected 0", n_done);
        end
    endtask

    task automatic test_pause();
        int step_at [$];
        int exp_at  [4];
        logic [PH_W-1:0] prev;
        exp_at = '{2, 9, 11, 13};
        reset_pulse();
        dir = 1'b0; steps = 8'd4; div = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            pause = (e >= 3 && e <= 7);
            prev  = dut_phase;
            tick();
            if (dut_phase !== prev) step_at.push_back(e);
            n_checks++;
            if (obs_vec() !== exp_vec() || dut_done !== (e == 13)) begin
                n_errors++;
                $display("FAIL pause_cycle %0d: got %b expected %b", e, obs_vec(), exp_vec());
            end
        end
        pause = 1'b0;
        n_checks++;
        if (step_at.size() != 4 || step_at[0] != exp_at[0] || step_at[1] != exp_at[1] ||
            step_at[2] != exp_at[2] || step_at[3] != exp_at[3]) begin
            n_errors++;
            $display("FAIL pause_timing: got %0d steps ending at edge %0d, expected steps at 2,9,11,13",
                     step_at.size(), (step_at.size() > 0) ? step_at[$] : -1);
        end
    endtask

    task automatic test_abort();
        reset_pulse();
        dir = 1'b0; steps = 8'd10; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_checks++;
        if (obs_vec() !== 9'b0) begin
            n_errors++;
            $display("FAIL abort_reset: got %b expected %b", obs_vec(), 9'b0);
        end
        tick();
        n_checks++;
        if (obs_vec() !== 9'b0 || obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL abort_reset_after: got %b expected %b", obs_vec(), 9'b0);
        end
        // stop coinciding with a due step suppresses that step
        steps = 8'd5; div = 8'd1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (dut_phase !== 3'd0 || dut_busy !== 1'b0 || dut_done !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_errors++;
            $display("FAIL stop_on_step: got %b expected phase=0 busy=0 done=0", obs_vec());
        end
    endtask

    task automatic test_start_while_busy();
        dir = 1'b0; steps = 8'd4; div = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dir = 1'b1; steps = 8'd1; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 3; e <= 17; e++) begin
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec() || dut_done !== (e == 16)) begin
                n_errors++;
                $display("FAIL busy_start_cycle %0d: got %b expected %b", e, obs_vec(), exp_vec());
            end
            if (e == 4 || e == 16) begin
                n_checks++;
                if (dut_phase !== ((e == 4) ? 3'd1 : 3'd4)) begin
                    n_errors++;
                    $display("FAIL busy_start_phase %0d: got %0d expected %0d", e, dut_phase, (e == 4) ? 1 : 4);
                end
            end
        end
    endtask

    task automatic test_done_restart();
        dir = 1'b0; steps = 8'd2; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        n_checks++;
        if (dut_done !== 1'b1 || dut_busy !== 1'b0 || dut_phase !== 3'd6) begin
            n_errors++;
            $display("FAIL restart_done: got %b expected phase=6 busy=0 done=1", obs_vec());
        end
        dir = 1'b1; steps = 8'd1; div = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (dut_busy !== 1'b1 || dut_done !== 1'b0 || dut_phase !== 3'd6) begin
            n_errors++;
            $display("FAIL restart_accept: got %b expected phase=6 busy=1 done=0", obs_vec());
        end
        tick();
        n_checks++;
        if (dut_done !== 1'b1 || dut_busy !== 1'b0 || dut_phase !== 3'd5 || dut_pattern !== 4'b0111) begin
            n_errors++;
            $display("FAIL restart_finish: got %b expected pattern=0111 phase=5 busy=0 done=1", obs_vec());
        end
        tick();
        n_checks++;
        if (dut_done !== 1'b0) begin
            n_errors++;
            $display("FAIL restart_single_pulse: got done=%b expected 0", dut_done);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            rst   = ($urandom_range(0, 149) != 0);
            start = ($urandom_range(0, 7) == 0);
            dir   = 1'($urandom_range(0, 1));
            steps = CNT_W'($urandom_range(0, 6));
            div   = DIV_W'($urandom_range(0, 3));
            pause = ($urandom_range(0, 7) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            tick();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_errors++;
                $display("FAIL random_cycle %0d: got %b expected %b", k, obs_vec(), exp_vec());
            end
        end
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; dir = 1'b0; steps = '0; div = '0;
        pause = 1'b0; stop = 1'b0;
        test_reset();
        test_forward();
        test_reverse();
        test_continuous();
        test_pause();
        test_abort();
        test_start_while_busy();
        test_done_restart();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
